cascade_time_counter: RTL and testbench

//   Parametrised multi-level cascaded counter for time-of-day / stopwatch use.

---
 rtl/cascade_time_counter.sv | 111 +++++++++++
 tb/tb_cascade_time_counter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cascade_time_counter.sv
`timescale 1ns/1ps
// Cascaded up/down time counter: prescaler tick advances LEVELS wrapping fields; value/tick/carry/wrap/alarm are registered, one cycle after the event.
// Backpressure: a load is taken when load_valid & load_ready; load_ready then drops for one cycle, and a load overrides a same-cycle tick.
module cascade_time_counter #(
  parameter int CLK_FREQ = 1000000,
  parameter int TICK_HZ  = 1,
  parameter int LEVELS   = 3,
  parameter int DIGIT_W  = 6,
  parameter logic [LEVELS*DIGIT_W-1:0] LIMITS = {6'd24, 6'd60, 6'd60}
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enabled,
  input  logic                      down,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [LEVELS*DIGIT_W-1:0] load_value,
  input  logic                      alarm_en,
  input  logic [LEVELS*DIGIT_W-1:0] alarm_value,
  output logic [LEVELS*DIGIT_W-1:0] value,
  output logic                      tick,
  output logic [LEVELS-1:0]         carry,
  output logic                      wrap,
  output logic                      alarm
);

  localparam int DIV = (CLK_FREQ / TICK_HZ < 1) ? 1 : CLK_FREQ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int VW  = LEVELS * DIGIT_W;
  localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

  logic [PW-1:0]      prescaler;
  logic               armed;
  logic               ps_tick;
  logic               load_fire;
  logic               step_evt;
  logic               chain;
  logic               term;
  logic [DIGIT_W:0]   lim;
  logic [DIGIT_W:0]   lim_m1;
  logic [DIGIT_W-1:0] fld;
  logic [DIGIT_W-1:0] ld_fld;
  logic [VW-1:0]      tick_val;
  logic [VW-1:0]      load_val;
  logic [VW-1:0]      value_nxt;
  logic [LEVELS-1:0]  carry_nxt;

  always_comb begin
    load_fire = load_valid & load_ready;
    ps_tick   = enabled & armed & (prescaler == PS_LAST);
    chain     = 1'b1;
    term      = 1'b0;
    lim       = '0;
    lim_m1    = '0;
    fld       = '0;
    ld_fld    = '0;
    tick_val  = value;
    load_val  = '0;
    carry_nxt = '0;
    for (int i = 0; i < LEVELS; i++) begin
      // A limit field of zero encodes the full 2^DIGIT_W range.
      lim    = {(LIMITS[i*DIGIT_W +: DIGIT_W] == '0), LIMITS[i*DIGIT_W +: DIGIT_W]};
      lim_m1 = lim - 1'b1;
      fld    = value[i*DIGIT_W +: DIGIT_W];
      if (down)
        term = (fld == '0) || ({1'b0, fld} >= lim);
      else
        term = ({1'b0, fld} >= lim_m1);
      if (chain) begin
        if (down)
          tick_val[i*DIGIT_W +: DIGIT_W] = term ? lim_m1[DIGIT_W-1:0] : fld - 1'b1;
        else
          tick_val[i*DIGIT_W +: DIGIT_W] = term ? '0 : fld + 1'b1;
      end
      carry_nxt[i] = chain & term;
      chain        = chain & term;
      ld_fld       = load_value[i*DIGIT_W +: DIGIT_W];
      load_val[i*DIGIT_W +: DIGIT_W] = ({1'b0, ld_fld} < lim) ? ld_fld : '0;
    end
    step_evt  = load_fire | ps_tick;
    value_nxt = load_fire ? load_val : (ps_tick ? tick_val : value);
  end

  // The prescaler starts on the edge after load_ready first rises, so the
  // first tick lands DIV edges after that point.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler  <= '0;
      armed      <= 1'b0;
      load_ready <= 1'b0;
      value      <= '0;
      tick       <= 1'b0;
      carry      <= '0;
      wrap       <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      armed      <= 1'b1;
      load_ready <= ~load_fire;
      value      <= value_nxt;
      if (load_fire || ps_tick)
        prescaler <= '0;
      else if (enabled && armed)
        prescaler <= prescaler + 1'b1;
      tick  <= ps_tick & ~load_fire;
      carry <= (ps_tick & ~load_fire) ? carry_nxt : '0;
      wrap  <= ps_tick & ~load_fire & (&carry_nxt);
      alarm <= alarm_en & step_evt & (value_nxt != value) & (value_nxt == alarm_value);
    end
  end

endmodule

// File: tb/tb_cascade_time_counter.sv
`timescale 1ns/1ps
// Directed bench: stimulus pushes expected tick/load events, a negedge monitor pops and compares them.
module tb_cascade_time_counter;

  typedef struct packed {
    logic        tk;
    logic [17:0] val;
    logic [2:0]  cy;
    logic        wr;
    logic        al;
  } ev_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        enabled;
  logic        down;
  logic        load_valid;
  logic        load_ready;
  logic [17:0] load_value;
  logic        alarm_en;
  logic [17:0] alarm_value;
  logic [17:0] value;
  logic        tick;
  logic [2:0]  carry;
  logic        wrap;
  logic        alarm;

  int   vectors = 0;
  int   miscompares = 0;
  ev_t  exp_q[$];
  logic prev_ready = 1'b0;

  cascade_time_counter #(
    .CLK_FREQ(4), .TICK_HZ(1), .LEVELS(3), .DIGIT_W(6),
    .LIMITS({6'd24, 6'd60, 6'd60})
  ) dut (
    .clock(clock), .reset(reset), .enabled(enabled), .down(down),
    .load_valid(load_valid), .load_ready(load_ready), .load_value(load_value),
    .alarm_en(alarm_en), .alarm_value(alarm_value), .value(value),
    .tick(tick), .carry(carry), .wrap(wrap), .alarm(alarm)
  );

  always #5 clock = ~clock;

  function automatic logic [17:0] hms(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
    return {h, m, s};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic tk, input logic [17:0] v, input logic [2:0] c,
                      input logic w, input logic al);
    ev_t e;
    e.tk = tk; e.val = v; e.cy = c; e.wr = w; e.al = al;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Monitor: an event is a tick pulse or load_ready falling after an accepted load.
  always @(negedge clock) begin
    ev_t a;
    ev_t e;
    if (!reset && (tick || (prev_ready && !load_ready))) begin
      a.tk = tick; a.val = value; a.cy = carry; a.wr = wrap; a.al = alarm;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_event: got %0h expected none", a);
      end else begin
        e = exp_q.pop_front();
        chk("event", 64'(a), 64'(e));
      end
    end
    prev_ready = load_ready;
  end

  initial begin
    reset = 1'b1; enabled = 1'b0; down = 1'b0; load_valid = 1'b0;
    load_value = '0; alarm_en = 1'b0; alarm_value = '0;
    cyc(3);
    chk("rst_value", 64'(value), 64'(0));
    chk("rst_tick", 64'(tick), 64'(0));
    chk("rst_carry", 64'(carry), 64'(0));
    chk("rst_wrap", 64'(wrap), 64'(0));
    chk("rst_alarm", 64'(alarm), 64'(0));
    chk("rst_ready", 64'(load_ready), 64'(0));

    // Free run from reset
    push(1'b1, hms(6'd0, 6'd0, 6'd1), 3'b000, 1'b0, 1'b0);
    push(1'b1, hms(6'd0, 6'd0, 6'd2), 3'b000, 1'b0, 1'b0);
    push(1'b1, hms(6'd0, 6'd0, 6'd3), 3'b000, 1'b0, 1'b0);
    reset = 1'b0; enabled = 1'b1;
    cyc(1);
    chk("ready_rise", 64'(load_ready), 64'(1));
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      chk("first_tick_timing", 64'(tick), 64'(k == 4));
    end
    cyc(8);

    // Up wrap of every level
    push(1'b0, hms(6'd23, 6'd59, 6'd59), 3'b000, 1'b0, 1'b0);
    push(1'b1, hms(6'd0, 6'd0, 6'd0), 3'b111, 1'b1, 1'b0);
    load_value = hms(6'd23, 6'd59, 6'd59); load_valid = 1'b1;
    cyc(1);
    load_valid = 1'b0;
    cyc(4);

    // Down wrap of every level
    push(1'b0, hms(6'd0, 6'd0, 6'd0), 3'b000, 1'b0, 1'b0);
    push(1'b1, hms(6'd23, 6'd59, 6'd59), 3'b111, 1'b1, 1'b0);
    down = 1'b1; load_value = '0; load_valid = 1'b1;
    cyc(1);
    load_valid = 1'b0;
    cyc(4);
    down = 1'b0;

    // Out-of-range load landing on a would-be tick edge
    cyc(3);
    push(1'b0, hms(6'd0, 6'd0, 6'd5), 3'b000, 1'b0, 1'b0);
    push(1'b1, hms(6'd0, 6'd0, 6'd6), 3'b000, 1'b0, 1'b0);
    load_value = hms(6'd30, 6'd61, 6'd5); load_valid = 1'b1;
    cyc(1);
    load_valid = 1'b0;
    chk("load_ready_low", 64'(load_ready), 64'(0));
    chk("tick_suppressed", 64'(tick), 64'(0));
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      if (k == 1) chk("load_ready_back", 64'(load_ready), 64'(1));
      chk("tick_after_load", 64'(tick), 64'(k == 4));
    end

    // Freeze with prescaler at 2
    cyc(2);
    enabled = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      chk("frozen", 64'({value, tick}), 64'({hms(6'd0, 6'd0, 6'd6), 1'b0}));
    end
    push(1'b1, hms(6'd0, 6'd0, 6'd7), 3'b000, 1'b0, 1'b0);
    enabled = 1'b1;
    cyc(1);
    chk("resume_no_tick", 64'(tick), 64'(0));
    cyc(1);
    chk("resume_tick", 64'(tick), 64'(1));

    // Alarm on minute rollover
    alarm_en = 1'b1; alarm_value = hms(6'd0, 6'd1, 6'd0);
    push(1'b0, hms(6'd0, 6'd0, 6'd59), 3'b000, 1'b0, 1'b0);
    push(1'b1, hms(6'd0, 6'd1, 6'd0), 3'b001, 1'b0, 1'b1);
    load_value = hms(6'd0, 6'd0, 6'd59); load_valid = 1'b1;
    cyc(1);
    load_valid = 1'b0;
    cyc(4);
    cyc(1);
    chk("alarm_one_cycle", 64'({alarm, value}), 64'({1'b0, hms(6'd0, 6'd1, 6'd0)}));

    // Asynchronous reset mid-count with a load pending
    cyc(1);
    #2;
    reset = 1'b1; load_valid = 1'b1;
    #1;
    chk("async_rst_value", 64'(value), 64'(0));
    chk("async_rst_flags", 64'({tick, carry, wrap, alarm, load_ready}), 64'(0));
    cyc(2);
    load_valid = 1'b0; reset = 1'b0;
    cyc(1);
    chk("post_rst", 64'({load_ready, value}), 64'({1'b1, 18'd0}));

    cyc(2);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
